// File: rtl/flash_qspi_xip_reader.sv
// Quad-I/O (0xEB) flash line reader with programmable SCK divider, dummy count,
// chip-select high time and continuous-read (XIP) entry/exit.
module flash_qspi_xip_reader #(
    parameter int LINE_SIZE = 128,
    parameter int DUMMY     = 4,
    parameter int DIV       = 1,
    parameter int XIP       = 1,
    parameter int CSH       = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [23:0]          addr,
    input  logic                 rd,
    input  logic                 xip_exit,
    output logic                 busy,
    output logic                 done,
    output logic [LINE_SIZE-1:0] line,
    output logic                 sck,
    output logic                 ce_n,
    input  logic [3:0]           din,
    output logic [3:0]           dout,
    output logic                 douten
);

    localparam logic [7:0]  CMD_BYTE  = 8'hEB;
    localparam logic [23:0] OFF_MASK  = 24'(LINE_SIZE / 8 - 1);
    localparam logic [3:0]  DIV_LAST  = 4'(DIV - 1);
    localparam logic [3:0]  CSH_LAST  = 4'(CSH - 1);
    localparam logic [7:0]  DUMMY_LEN = 8'(DUMMY);
    localparam logic [7:0]  DATA_LEN  = 8'(LINE_SIZE / 4);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_CSH
    } state_t;

    state_t               state_reg, state_next;
    logic [7:0]           cyc_reg, cyc_next;
    logic [3:0]           div_reg;
    logic [3:0]           csh_reg;
    logic                 sck_reg, ce_n_reg, fin_reg, done_reg, douten_reg;
    logic                 xip_on_reg, xip_exit_reg;
    logic [3:0]           dout_reg;
    logic [23:0]          addr_reg;
    logic [LINE_SIZE-1:0] line_reg;

    logic                 launch, shifting, tick, sck_fall, phase_last;
    logic [7:0]           phase_len;
    logic [23:0]          addr_src;
    logic                 exit_src;

    // Nibble presented on the IO bus for a given phase position.
    function automatic logic [3:0] nib_for(input state_t st, input logic [7:0] cyc,
                                           input logic [23:0] a, input logic ex);
        logic [23:0] sh;
        logic [7:0]  mode_byte;
        logic [3:0]  nib;
        sh        = a << {cyc[2:0], 2'b00};
        mode_byte = ((XIP != 0) && !ex) ? 8'hA5 : 8'hFF;
        case (st)
            S_CMD:   nib = {3'b000, CMD_BYTE[3'd7 - cyc[2:0]]};
            S_ADDR:  nib = sh[23:20];
            S_MODE:  nib = cyc[0] ? mode_byte[3:0] : mode_byte[7:4];
            default: nib = 4'd0;
        endcase
        return nib;
    endfunction

    assign launch     = (state_reg == S_IDLE) && rd;
    assign shifting   = (state_reg != S_IDLE) && (state_reg != S_CSH) && !fin_reg;
    assign tick       = shifting && (div_reg == DIV_LAST);
    assign sck_fall   = tick && sck_reg;
    assign phase_last = (cyc_reg == phase_len - 8'd1);
    assign addr_src   = launch ? (addr & ~OFF_MASK) : addr_reg;
    assign exit_src   = launch ? xip_exit : xip_exit_reg;

    always_comb begin
        phase_len = 8'd1;
        case (state_reg)
            S_CMD:   phase_len = 8'd8;
            S_ADDR:  phase_len = 8'd6;
            S_MODE:  phase_len = 8'd2;
            S_DUMMY: phase_len = DUMMY_LEN;
            S_DATA:  phase_len = DATA_LEN;
            default: phase_len = 8'd1;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        cyc_next   = cyc_reg;
        case (state_reg)
            S_IDLE: begin
                if (rd) begin
                    state_next = xip_on_reg ? S_ADDR : S_CMD;
                    cyc_next   = 8'd0;
                end
            end
            S_CSH: begin
                if (csh_reg == CSH_LAST) state_next = S_IDLE;
            end
            default: begin
                if (fin_reg) begin
                    state_next = S_CSH;
                end else if (sck_fall) begin
                    if (phase_last) begin
                        cyc_next = 8'd0;
                        case (state_reg)
                            S_CMD:   state_next = S_ADDR;
                            S_ADDR:  state_next = S_MODE;
                            S_MODE:  state_next = (DUMMY == 0) ? S_DATA : S_DUMMY;
                            S_DUMMY: state_next = S_DATA;
                            default: begin
                                // Last data nibble: hold position for the closing cycle.
                                state_next = state_reg;
                                cyc_next   = cyc_reg;
                            end
                        endcase
                    end else begin
                        cyc_next = cyc_reg + 8'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            cyc_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            cyc_reg   <= cyc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg      <= 4'd0;
            csh_reg      <= 4'd0;
            sck_reg      <= 1'b0;
            ce_n_reg     <= 1'b1;
            fin_reg      <= 1'b0;
            done_reg     <= 1'b0;
            douten_reg   <= 1'b0;
            dout_reg     <= 4'd0;
            xip_on_reg   <= 1'b0;
            xip_exit_reg <= 1'b0;
            addr_reg     <= 24'd0;
        end else begin
            done_reg <= 1'b0;
            if (launch) begin
                addr_reg     <= addr_src;
                xip_exit_reg <= xip_exit;
                ce_n_reg     <= 1'b0;
                sck_reg      <= 1'b0;
                div_reg      <= 4'd0;
                fin_reg      <= 1'b0;
            end
            if (shifting) begin
                if (tick) begin
                    div_reg <= 4'd0;
                    sck_reg <= ~sck_reg;
                end else begin
                    div_reg <= div_reg + 4'd1;
                end
            end
            if (sck_fall && (state_reg == S_DATA) && phase_last) fin_reg <= 1'b1;
            if ((state_reg == S_DATA) && fin_reg) begin
                fin_reg    <= 1'b0;
                done_reg   <= 1'b1;
                ce_n_reg   <= 1'b1;
                sck_reg    <= 1'b0;
                csh_reg    <= 4'd0;
                xip_on_reg <= (XIP != 0) && !xip_exit_reg;
            end
            if (state_reg == S_CSH) csh_reg <= csh_reg + 4'd1;
            if (launch || sck_fall) begin
                dout_reg   <= nib_for(state_next, cyc_next, addr_src, exit_src);
                douten_reg <= (state_next == S_CMD) || (state_next == S_ADDR) ||
                              (state_next == S_MODE);
            end
        end
    end

    // Nibble k lands in byte k/2, high nibble first: bit offset 4*(k^1).
    always_ff @(posedge clk) begin
        if (sck_fall && (state_reg == S_DATA))
            line_reg[{cyc_reg ^ 8'd1, 2'b00} +: 4] <= din;
    end

    assign busy   = (state_reg != S_IDLE);
    assign done   = done_reg;
    assign line   = line_reg;
    assign sck    = sck_reg;
    assign ce_n   = ce_n_reg;
    assign dout   = dout_reg;
    assign douten = douten_reg;

endmodule

// File: tb/tb_flash_qspi_xip_reader.sv
// Directed bench for flash_qspi_xip_reader: a default instance and a
// DIV=3 / DUMMY=0 / 256-bit instance sharing one behavioural flash model.
module tb_flash_qspi_xip_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n = 1'b0;
    logic [23:0]  addr_a = 24'd0, addr_b = 24'd0;
    logic         rd_a = 1'b0, rd_b = 1'b0;
    logic         xip_exit_a = 1'b0, xip_exit_b = 1'b0;
    logic         busy_a, done_a, sck_a, ce_n_a, douten_a;
    logic         busy_b, done_b, sck_b, ce_n_b, douten_b;
    logic [127:0] line_a;
    logic [255:0] line_b;
    logic [3:0]   dout_a, dout_b;
    logic [3:0]   din_m = 4'd0;

    flash_qspi_xip_reader u_dut_a (
        .clk(clk), .rst_n(rst_n), .addr(addr_a), .rd(rd_a), .xip_exit(xip_exit_a),
        .busy(busy_a), .done(done_a), .line(line_a), .sck(sck_a), .ce_n(ce_n_a),
        .din(din_m), .dout(dout_a), .douten(douten_a)
    );

    flash_qspi_xip_reader #(.LINE_SIZE(256), .DUMMY(0), .DIV(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .addr(addr_b), .rd(rd_b), .xip_exit(xip_exit_b),
        .busy(busy_b), .done(done_b), .line(line_b), .sck(sck_b), .ce_n(ce_n_b),
        .din(din_m), .dout(dout_b), .douten(douten_b)
    );

    bit           sel = 1'b0;
    logic         busy_s, done_s, sck_s, ce_n_s, douten_s;
    logic [3:0]   dout_s;
    logic [255:0] line_s;
    assign busy_s   = sel ? busy_b   : busy_a;
    assign done_s   = sel ? done_b   : done_a;
    assign sck_s    = sel ? sck_b    : sck_a;
    assign ce_n_s   = sel ? ce_n_b   : ce_n_a;
    assign douten_s = sel ? douten_b : douten_a;
    assign dout_s   = sel ? dout_b   : dout_a;
    assign line_s   = sel ? line_b   : {128'd0, line_a};

    // Flash model: logs the bus on each SCK rise, drives data nibbles after the header.
    int         cyc_ctr = 0;
    int         rise_cnt = 0, last_rises = 0, hdr_len = 0;
    logic [7:0] seed = 8'd0;
    logic [3:0] dlog [0:255];
    logic       oelog [0:255];
    int         rise_t [0:1];
    int         ce_fall_a = 0, done_cnt_a = 0;

    always @(posedge clk) cyc_ctr++;
    always @(negedge ce_n_a) ce_fall_a++;
    always @(posedge done_a) done_cnt_a++;

    always @(posedge sck_s or posedge ce_n_s) begin
        if (ce_n_s) begin
            last_rises = rise_cnt;
            rise_cnt   = 0;
        end else begin
            logic [7:0] b;
            int         k;
            if (rise_cnt < 256) begin
                dlog[rise_cnt]  = dout_s;
                oelog[rise_cnt] = douten_s;
            end
            if (rise_cnt < 2) rise_t[rise_cnt] = cyc_ctr;
            if (rise_cnt >= hdr_len) begin
                k     = rise_cnt - hdr_len;
                b     = 8'(k / 2) ^ seed;
                din_m = (k % 2 == 0) ? b[7:4] : b[3:0];
            end else begin
                din_m = 4'd0;
            end
            rise_cnt++;
        end
    end

    int n_checks = 0, n_pass = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Caller must be at a negedge; rd is driven immediately (back-to-back capable).
    task automatic fetch(input logic [23:0] a, input logic ex, input logic [7:0] sd,
                         input bit exp_cmd, input int exp_lat, input logic [7:0] exp_mode,
                         input int line_bits, input int dummy, input int div);
        int           lat, n, idx, start;
        logic [7:0]   cmd;
        logic [2:0]   hi;
        logic [23:0]  got_addr;
        logic [255:0] exp_line;
        hdr_len = (exp_cmd ? 8 : 0) + 8 + dummy;
        seed    = sd;
        if (sel) begin addr_b = a; xip_exit_b = ex; rd_b = 1'b1; end
        else     begin addr_a = a; xip_exit_a = ex; rd_a = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        rd_a  = 1'b0;
        rd_b  = 1'b0;
        start = cyc_ctr;
        check("ce_fall", ce_n_s, 1'b0);
        check("sck_low_at_start", sck_s, 1'b0);
        lat = 0;
        while (lat < 3000) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done_s) break;
        end
        check("latency", lat, exp_lat);
        check("busy_at_done", busy_s, 1'b1);
        check("ce_n_at_done", ce_n_s, 1'b1);
        check("sck_cycles", last_rises, hdr_len + line_bits / 4);
        check("sck_first_rise", rise_t[0] - start, div);
        check("sck_period", rise_t[1] - rise_t[0], 2 * div);
        idx = 0;
        if (exp_cmd) begin
            cmd = 8'd0;
            hi  = 3'd0;
            for (int j = 0; j < 8; j++) begin
                cmd = {cmd[6:0], dlog[j][0]};
                hi  = hi | dlog[j][3:1];
            end
            check("cmd_byte", cmd, 8'hEB);
            check("cmd_upper_io", hi, 3'd0);
            idx = 8;
        end
        got_addr = 24'd0;
        for (int j = 0; j < 6; j++) got_addr = {got_addr[19:0], dlog[idx + j]};
        check("addr", got_addr, a & ~24'(line_bits / 8 - 1));
        check("mode", {dlog[idx + 6], dlog[idx + 7]}, exp_mode);
        check("oe_mode", oelog[idx + 7], 1'b1);
        check("oe_data", oelog[hdr_len], 1'b0);
        exp_line = 256'd0;
        for (int i = 0; i < line_bits / 8; i++) exp_line[8 * i +: 8] = 8'(i) ^ sd;
        check("line", line_s, exp_line);
        n = 0;
        while (busy_s && n < 100) begin
            if (n == 1) check("done_pulse", done_s, 1'b0);
            n++;
            @(negedge clk);
        end
        check("csh_cycles", n, 2);
    endtask

    initial begin
        int falls0, dn0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_ce_n", ce_n_a, 1'b1);
        check("rst_sck", sck_a, 1'b0);
        check("rst_douten", douten_a, 1'b0);
        check("rst_dout", dout_a, 4'd0);

        fetch(24'h001234, 1'b0, 8'h00, 1'b1, 105, 8'hA5, 128, 4, 1);
        fetch(24'h000040, 1'b0, 8'h40, 1'b0,  89, 8'hA5, 128, 4, 1);
        fetch(24'h000085, 1'b1, 8'h5A, 1'b0,  89, 8'hFF, 128, 4, 1);
        fetch(24'h00FFFF, 1'b0, 8'hC3, 1'b1, 105, 8'hA5, 128, 4, 1);

        // rd pulsed mid-DATA and during CSH must be ignored.
        falls0 = ce_fall_a;
        fork
            fetch(24'h000100, 1'b0, 8'h21, 1'b0, 89, 8'hA5, 128, 4, 1);
            begin
                repeat (60) @(negedge clk);
                rd_a = 1'b1;
                @(negedge clk);
                rd_a = 1'b0;
                repeat (29) @(negedge clk);
                rd_a = 1'b1;
                @(negedge clk);
                rd_a = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        check("busy_ignored_rd", busy_a, 1'b0);
        check("ce_falls_ignored_rd", ce_fall_a - falls0, 1);

        // Reset asserted mid-DATA.
        hdr_len = 16;
        addr_a  = 24'h000300;
        rd_a    = 1'b1;
        @(negedge clk);
        rd_a = 1'b0;
        repeat (59) @(negedge clk);
        dn0   = done_cnt_a;
        rst_n = 1'b0;
        #1;
        check("abort_ce_n", ce_n_a, 1'b1);
        check("abort_sck", sck_a, 1'b0);
        repeat (3) @(negedge clk);
        check("abort_busy", busy_a, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_no_done", done_cnt_a - dn0, 0);
        fetch(24'h000200, 1'b0, 8'h11, 1'b1, 105, 8'hA5, 128, 4, 1);

        sel = 1'b1;
        @(negedge clk);
        fetch(24'h123456, 1'b0, 8'h77, 1'b1, 481, 8'hA5, 256, 0, 3);
        fetch(24'h000020, 1'b1, 8'h99, 1'b0, 433, 8'hFF, 256, 0, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
